// File: rtl/painel_tick_ctrl.sv
// painel_tick_ctrl: display-scan / message-scroll tick generator with IDLE/RUN/PAUSE control.
// Latency: ticks are combinational from the counters, so they fall in the cycle the count reaches DIV-1.
//    Counters, digit_sel and scroll_pos update on the edge that ends that cycle.
// Backpressure: none. pause freezes all progress, stop clears it, and rst overrides both.
//
// Ports:
//    clk, rst                  single clock, synchronous active-high reset
//    start, pause, stop        control requests; priority is stop > pause > start
//    scan_tick, scroll_tick    one-cycle enables, asserted only while counting in RUN
//    digit_sel [3:0]           one-hot active digit, rotated on each scan_tick
//    scroll_pos [4:0]          message offset, advanced on each scroll_tick
//    wrap                      scroll_tick in which scroll_pos wraps from MSG_LEN-1 to 0
//    running                   high only in RUN
//
// Build option: define PAINEL_FASTSIM_EN to replace SCROLL_DIV with 4*SCAN_DIV.
module painel_tick_ctrl #(
   parameter int SCAN_DIV   = 32,
   parameter int SCROLL_DIV = 16777216,
   parameter int MSG_LEN    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   output logic       scan_tick,
   output logic       scroll_tick,
   output logic [3:0] digit_sel,
   output logic [4:0] scroll_pos,
   output logic       wrap,
   output logic       running
);

`ifdef PAINEL_FASTSIM_EN
   localparam int SCROLL_EFF = 4 * SCAN_DIV;
`else
   localparam int SCROLL_EFF = SCROLL_DIV;
`endif

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
   localparam logic [23:0]       SCROLL_LAST = 24'(SCROLL_EFF - 1);
   localparam logic [4:0]        POS_LAST    = 5'(MSG_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [23:0]       scroll_cnt_q, scroll_cnt_d;
   logic [3:0]        digit_sel_q, digit_sel_d;
   logic [4:0]        scroll_pos_q, scroll_pos_d;

   logic advance;
   logic scan_hit;
   logic scroll_hit;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic. A cycle in which pause is high never starts or resumes the run.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start && !pause) state_d = S_RUN;
            S_RUN:   if (pause)           state_d = S_PAUSE;
            S_PAUSE: if (start && !pause) state_d = S_RUN;
            default:                      state_d = S_IDLE;
         endcase
      end
   end

   // Output logic. A RUN cycle in which pause or stop is sampled does not count:
   // it produces no tick and the counters hold (pause) or clear (stop).
   always_comb begin
      advance     = !rst && (state_q == S_RUN) && !pause && !stop;
      scan_hit    = (scan_cnt_q == SCAN_LAST);
      scroll_hit  = (scroll_cnt_q == SCROLL_LAST);
      scan_tick   = advance && scan_hit;
      scroll_tick = advance && scroll_hit;
      wrap        = scroll_tick && (scroll_pos_q == POS_LAST);
      running     = !rst && (state_q == S_RUN);
      digit_sel   = digit_sel_q;
      scroll_pos  = scroll_pos_q;
   end

   // Counter and position update. IDLE is entered only through rst or stop, and both
   // leave the counters at zero, so a fresh start always begins from zero.
   always_comb begin
      scan_cnt_d   = scan_cnt_q;
      scroll_cnt_d = scroll_cnt_q;
      digit_sel_d  = digit_sel_q;
      scroll_pos_d = scroll_pos_q;
      if (stop) begin
         scan_cnt_d   = '0;
         scroll_cnt_d = '0;
         digit_sel_d  = 4'b0001;
         scroll_pos_d = '0;
      end else if (advance) begin
         scan_cnt_d   = scan_hit   ? '0 : scan_cnt_q + 1'b1;
         scroll_cnt_d = scroll_hit ? '0 : scroll_cnt_q + 24'd1;
         if (scan_hit)
            digit_sel_d = {digit_sel_q[2:0], digit_sel_q[3]};
         if (scroll_hit)
            scroll_pos_d = (scroll_pos_q == POS_LAST) ? 5'd0 : scroll_pos_q + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q   <= '0;
         scroll_cnt_q <= '0;
         digit_sel_q  <= 4'b0001;
         scroll_pos_q <= '0;
      end else begin
         scan_cnt_q   <= scan_cnt_d;
         scroll_cnt_q <= scroll_cnt_d;
         digit_sel_q  <= digit_sel_d;
         scroll_pos_q <= scroll_pos_d;
      end
   end

endmodule

// File: tb/tb_painel_tick_ctrl.sv
// Directed bench for painel_tick_ctrl. The scroll divisor is set to 128, which is also
// 4*SCAN_DIV, so expected timing is identical with or without PAINEL_FASTSIM_EN.
// Tick times and scroll values are queued as the stimulus is driven. A negedge monitor
// pops the queues and compares against them.
module tb_painel_tick_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       pause;
   logic       stop;
   logic       scan_tick;
   logic       scroll_tick;
   logic [3:0] digit_sel;
   logic [4:0] scroll_pos;
   logic       wrap;
   logic       running;

   int tests = 0;
   int fails = 0;

   logic [31:0] cyc = 32'd0;

   typedef struct {
      logic [31:0] cyc;
      logic [4:0]  pos;
      logic        wrap;
   } scroll_exp_t;

   logic [31:0] scan_q[$];
   scroll_exp_t scroll_q[$];

   logic [31:0] c0, c1, r1, c2, e_cyc;
   scroll_exp_t se, mon_se;

   painel_tick_ctrl #(
      .SCAN_DIV  (32),
      .SCROLL_DIV(128),
      .MSG_LEN   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .scan_tick  (scan_tick),
      .scroll_tick(scroll_tick),
      .digit_sel  (digit_sel),
      .scroll_pos (scroll_pos),
      .wrap       (wrap),
      .running    (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (scan_tick) begin
         if (scan_q.size() == 0) begin
            check("scan_unexpected", 32'(scan_tick), 32'd0);
         end else begin
            e_cyc = scan_q.pop_front();
            check("scan_tick_cyc", cyc, e_cyc);
         end
      end
      if (scroll_tick) begin
         if (scroll_q.size() == 0) begin
            check("scroll_unexpected", 32'(scroll_tick), 32'd0);
         end else begin
            mon_se = scroll_q.pop_front();
            check("scroll_tick_cyc", cyc, mon_se.cyc);
            check("scroll_pos_at_tick", 32'(scroll_pos), 32'(mon_se.pos));
            check("wrap_at_tick", 32'(wrap), 32'(mon_se.wrap));
         end
      end else if (wrap) begin
         check("wrap_stray", 32'(wrap), 32'd0);
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;

      // Reset behaviour.
      step(1);
      check("rst_running", 32'(running), 32'd0);
      check("rst_scan_tick", 32'(scan_tick), 32'd0);
      check("rst_digit_sel", 32'(digit_sel), 32'h1);
      check("rst_scroll_pos", 32'(scroll_pos), 32'd0);
      step(2);
      rst = 1'b0;
      step(1);
      check("idle_running", 32'(running), 32'd0);

      // Free run for 700 RUN cycles: scan every 32 and scroll every 128, with a wrap on
      // the 4th scroll tick.
      start = 1'b1;
      step(1);
      start = 1'b0;
      c0 = cyc;                         // RUN cycle 1
      check("a_running", 32'(running), 32'd1);
      check("a_digit_start", 32'(digit_sel), 32'h1);
      for (int i = 1; i <= 21; i++) scan_q.push_back(c0 + 32'(32 * i) - 32'd1);
      for (int j = 1; j <= 5; j++) begin
         se.cyc  = c0 + 32'(128 * j) - 32'd1;
         se.pos  = 5'((j - 1) % 4);
         se.wrap = (j == 4);
         scroll_q.push_back(se);
      end
      for (int k = 2; k <= 700; k++) begin
         step(1);                       // now in RUN cycle k
         case (k)
            33:  check("a_digit_after_tick1", 32'(digit_sel), 32'h2);
            129: check("a_pos_1", 32'(scroll_pos), 32'd1);
            257: check("a_pos_2", 32'(scroll_pos), 32'd2);
            385: check("a_pos_3", 32'(scroll_pos), 32'd3);
            513: begin
               check("a_pos_0", 32'(scroll_pos), 32'd0);
               check("a_digit_16ticks", 32'(digit_sel), 32'h1);
            end
            641: check("a_pos_1b", 32'(scroll_pos), 32'd1);
            default: ;
         endcase
      end
      check("a_digit_21ticks", 32'(digit_sel), 32'h2);

      // start, pause and stop together from RUN: stop wins.
      start = 1'b1;
      pause = 1'b1;
      stop  = 1'b1;
      step(1);
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
      check("triple_running", 32'(running), 32'd0);
      check("triple_digit", 32'(digit_sel), 32'h1);
      check("triple_pos", 32'(scroll_pos), 32'd0);

      // Pause in RUN cycle 20, hold 50 cycles, then resume. The pause cycle does not
      // count, so 19 counts are banked and the tick comes 12 cycles after the first
      // resumed cycle.
      start = 1'b1;
      step(1);
      start = 1'b0;
      c1 = cyc;
      step(19);                         // RUN cycle 20
      check("b_cycle20", cyc, c1 + 32'd19);
      pause = 1'b1;
      step(1);
      check("b_paused_running", 32'(running), 32'd0);
      step(49);
      pause = 1'b0;
      start = 1'b1;
      step(1);
      start = 1'b0;
      r1 = cyc;
      check("b_resumed_running", 32'(running), 32'd1);
      scan_q.push_back(r1 + 32'd12);
      step(13);
      check("b_digit_after_resume_tick", 32'(digit_sel), 32'h2);

      // rst one cycle after a scan tick discards all progress.
      rst = 1'b1;
      #1;
      check("c_rst_running", 32'(running), 32'd0);
      step(1);
      rst = 1'b0;
      check("c_digit", 32'(digit_sel), 32'h1);
      check("c_pos", 32'(scroll_pos), 32'd0);
      check("c_running", 32'(running), 32'd0);

      // A fresh run must start from zero counts. The tick due in cycle 128 is suppressed
      // by pause.
      start = 1'b1;
      step(1);
      start = 1'b0;
      c2 = cyc;
      for (int i = 1; i <= 3; i++) scan_q.push_back(c2 + 32'(32 * i) - 32'd1);
      step(127);                        // RUN cycle 128
      pause = 1'b1;
      #1;
      check("d_pause_scan_low", 32'(scan_tick), 32'd0);
      check("d_pause_scroll_low", 32'(scroll_tick), 32'd0);
      step(1);
      pause = 1'b0;
      check("d_digit_3ticks", 32'(digit_sel), 32'h8);
      check("d_pos_held", 32'(scroll_pos), 32'd0);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("d_stop_running", 32'(running), 32'd0);
      check("d_stop_digit", 32'(digit_sel), 32'h1);
      step(2);

      check("scan_q_drained", 32'(scan_q.size()), 32'd0);
      check("scroll_q_drained", 32'(scroll_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/painel_tick_ctrl.md
PAINEL_TICK_CTRL -- requirements
Module: painel_tick_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 32: clk cycles per display-scan tick, legal range 2..256.
REQ-002 SHALL have parameter SCROLL_DIV, default 16777216: clk cycles per message-scroll tick, legal range 2..2^24.
REQ-003 SHALL have parameter MSG_LEN, default 16: number of scroll positions, legal range 2..32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to start or resume.
REQ-007 SHALL have port pause, input, 1 bit: request to freeze all counters.
REQ-008 SHALL have port stop, input, 1 bit: request to abort to idle and clear.
REQ-009 SHALL have port scan_tick, output, 1 bit: one-cycle enable pulse for the display multiplexer.
REQ-010 SHALL have port scroll_tick, output, 1 bit: one-cycle enable pulse for the message shift.
REQ-011 SHALL have port digit_sel, output, 4 bits: one-hot active display digit.
REQ-012 SHALL have port scroll_pos, output, 5 bits: current message offset.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse when scroll_pos wraps.
REQ-014 SHALL have port running, output, 1 bit: high only in state RUN.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and PAUSE.
REQ-016 SHALL give stop priority over pause, and pause priority over start, when they are asserted in the same cycle.
REQ-017 SHALL move to IDLE on stop from any state, clearing both counters, setting digit_sel=0001 and setting scroll_pos=0 on the same edge.
REQ-018 SHALL move from IDLE to RUN on start, with both counters at 0.
REQ-019 SHALL move from RUN to PAUSE on pause, and SHALL hold both counters, digit_sel and scroll_pos unchanged.
REQ-020 SHALL move from PAUSE to RUN on start, resuming the counts from the held values.
REQ-021 SHALL ignore pause in IDLE, and SHALL ignore start in RUN.
REQ-022 SHALL increment scan_cnt in RUN, wrapping from SCAN_DIV-1 to 0.
REQ-023 SHALL drive scan_tick = (state==RUN && scan_cnt==SCAN_DIV-1), so the first tick occurs in the SCAN_DIV-th RUN cycle.
REQ-024 SHALL rotate digit_sel left on the edge that ends a scan_tick cycle: 0001->0010->0100->1000->0001.
REQ-025 SHALL increment the 24-bit scroll_cnt in RUN independently of scan_cnt, wrapping from SCROLL_DIV-1 to 0.
REQ-026 SHALL drive scroll_tick on the same pattern as scan_tick, using scroll_cnt and SCROLL_DIV.
REQ-027 SHALL increment scroll_pos on each scroll_tick, wrapping from MSG_LEN-1 to 0.
REQ-028 SHALL assert wrap combinationally in the scroll_tick cycle in which scroll_pos==MSG_LEN-1.
REQ-029 SHALL hold scan_tick, scroll_tick and wrap low outside RUN, including in the cycle in which pause or stop is sampled.
REQ-030 SHALL run only on clk; no counter output SHALL be used as a clock.

Reset
REQ-031 SHALL on rst set state=IDLE, scan_cnt=0, scroll_cnt=0, digit_sel=0001 and scroll_pos=0.
REQ-032 SHALL hold scan_tick, scroll_tick, wrap and running at 0 while rst is high.
REQ-033 SHALL give rst priority over start, pause and stop; rst asserted mid-RUN SHALL discard all progress.

Configuration
REQ-034 SHALL, with macro PAINEL_FASTSIM_EN defined, use an effective scroll divisor of 4*SCAN_DIV (128 at defaults) in place of SCROLL_DIV.
REQ-035 SHALL, without PAINEL_FASTSIM_EN, use SCROLL_DIV exactly; all other behaviour SHALL be identical in both builds.

Verification
REQ-036 SHALL cover: rst, then start pulse at defaults -> scan_tick first high in RUN cycle 32, then every 32 cycles; digit_sel 0001->0010 after the first tick.
REQ-037 SHALL cover: PAINEL_FASTSIM_EN, MSG_LEN=4, run 4*128 cycles -> scroll_pos sequence 1,2,3,0, with wrap high once, on the 4th scroll_tick.
REQ-038 SHALL cover: pause at RUN cycle 20 held 50 cycles, then start -> next scan_tick 12 RUN cycles after resume, with no ticks during PAUSE.
REQ-039 SHALL cover: start, pause and stop asserted in the same cycle from RUN -> IDLE, digit_sel=0001, scroll_pos=0, running=0.
REQ-040 SHALL cover: rst asserted one cycle after scan_tick, with digit_sel=0010 -> next cycle digit_sel=0001, counters 0, state IDLE.
